// File: rtl/if_fetch.sv
// Instruction fetch front end: credit-limited request issue, in-order skid buffer and jump discard.
// Define IF_FETCH_PERF_EN to build the saturating stall/drop performance counters.
module if_fetch #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        jmp,
    input  logic [31:0] jmp_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    input  logic        fifo_full,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_drop_cnt
);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_DRAIN} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  out_q, out_d;
    logic [1:0]  disc_q, disc_d;
    logic [1:0]  occ_q, occ_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [31:0] buf_q [MAX_OUTSTANDING];
    logic [31:0] head;
    logic        gnt_fire, drop_rsp, push, pop, credit_ok;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Credits cover both in-flight requests and words parked in the skid buffer.
    assign credit_ok = ({1'b0, out_q} + {1'b0, occ_q}) < 3'(MAX_OUTSTANDING);
    assign gnt_fire  = imem_req & imem_gnt;
    assign drop_rsp  = imem_rvalid & (jmp | (disc_q != 2'd0));
    assign push      = imem_rvalid & ~drop_rsp;
    assign pop       = fifo_wr_en;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state_q <= S_BOOT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN, S_DRAIN: begin
                if (jmp)                  state_d = (disc_d != 2'd0) ? S_DRAIN : S_RUN;
                else if (disc_d == 2'd0)  state_d = S_RUN;
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        imem_req     = (state_q != S_BOOT) & credit_ok & ~jmp;
        imem_addr    = {pc_q[31:2], 2'b00};
        fifo_wr_en   = (occ_q != 2'd0) & ~fifo_full & ~jmp;
        fifo_wr_data = head;
    end

    always_comb begin
        pc_d     = pc_q;
        out_d    = out_q + 2'(gnt_fire) - 2'(imem_rvalid);
        disc_d   = disc_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (gnt_fire) pc_d = pc_q + 32'd4;
        if (jmp) begin
            // Anything still in flight after this cycle belongs to the old stream.
            pc_d     = jmp_addr & ~32'd3;
            disc_d   = out_d;
            occ_d    = 2'd0;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
        end else begin
            if (imem_rvalid && disc_q != 2'd0) disc_d = disc_q - 2'd1;
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            occ_d = occ_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pc_q     <= RESET_PC & ~32'd3;
            out_q    <= 2'd0;
            disc_q   <= 2'd0;
            occ_q    <= 2'd0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (!rstb)                                buf_q[i] <= 32'h0;
            else if (push && wr_ptr_q == 2'(i))       buf_q[i] <= imem_rdata;
        end
    end

    always_comb begin
        head = 32'h0;
        for (int i = 0; i < MAX_OUTSTANDING; i++)
            if (rd_ptr_q == 2'(i)) head = buf_q[i];
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] stall_q, drop_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            stall_q <= 32'h0;
            drop_q  <= 32'h0;
        end else begin
            if ((occ_q != 2'd0) && fifo_full && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
            if (drop_rsp && drop_q != 32'hFFFF_FFFF)                       drop_q  <= drop_q + 32'd1;
        end
    end

    assign perf_stall_cnt = stall_q;
    assign perf_drop_cnt  = drop_q;
`else
    assign perf_stall_cnt = 32'h0;
    assign perf_drop_cnt  = 32'h0;
`endif

endmodule
